// File: rtl/ram_stream_reader.sv
// Dumps a contiguous, wrapping range of a synchronous RAM as a valid/ready stream
// with a running checksum. A 2-entry FIFO hides the RAM's 1-cycle read latency.
module ram_stream_reader #(
    parameter int ADDR_SIZE = 18,
    parameter int WORD_SIZE = 18,
    parameter int MEM_SIZE  = 1024
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic [ADDR_SIZE-1:0] first_addr,
    input  logic [ADDR_SIZE-1:0] word_count,
    output logic [ADDR_SIZE-1:0] mem_addr,
    input  logic [WORD_SIZE-1:0] mem_data,
    output logic [WORD_SIZE-1:0] out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_last,
    output logic                 busy,
    output logic                 done,
    output logic [WORD_SIZE-1:0] checksum
);

    typedef enum logic [1:0] {IDLE, READ, DRAIN, FINISH} state_t;

    localparam logic [ADDR_SIZE-1:0] LAST_ADDR = ADDR_SIZE'(MEM_SIZE - 1);
    localparam logic [ADDR_SIZE-1:0] ONE       = ADDR_SIZE'(1);

    state_t               state, state_next;
    logic [ADDR_SIZE-1:0] count_q, issued, sent;
    logic [ADDR_SIZE-1:0] rd_addr, addr_hold;
    logic [WORD_SIZE-1:0] fifo_head, fifo_tail;
    logic [1:0]           fifo_count;
    logic                 inflight, accept, issue, pop;
    logic [2:0]           occupancy;

    assign out_valid = (fifo_count != 2'd0);
    assign out_data  = fifo_head;
    assign pop       = out_valid && out_ready;
    assign out_last  = out_valid && (sent == count_q - ONE);
    // Slots already committed this cycle: stored words plus the read in flight,
    // minus the word leaving now.
    assign occupancy = 3'(fifo_count) + 3'(inflight) - 3'(pop);
    assign mem_addr  = issue ? rd_addr : addr_hold;

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        issue      = 1'b0;
        accept     = 1'b0;
        case (state)
            IDLE, FINISH: begin
                done       = (state == FINISH);
                state_next = IDLE;
                if (start) begin
                    accept     = 1'b1;
                    state_next = (word_count == '0) ? FINISH : READ;
                end
            end
            READ: begin
                busy  = 1'b1;
                issue = (issued != count_q) && (occupancy < 3'd2);
                if (issue && (issued == count_q - ONE)) state_next = DRAIN;
            end
            DRAIN: begin
                busy = 1'b1;
                if (pop && (sent == count_q - ONE)) state_next = FINISH;
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: all state below uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            count_q    <= '0;
            issued     <= '0;
            sent       <= '0;
            rd_addr    <= '0;
            addr_hold  <= '0;
            checksum   <= '0;
            inflight   <= 1'b0;
            fifo_count <= 2'd0;
            // NOTE: the two FIFO data words are reset too, because out_data
            // must read zero after reset; larger storage would be left unreset.
            fifo_head  <= '0;
            fifo_tail  <= '0;
        end else begin
            state    <= state_next;
            inflight <= issue;

            if (accept) begin
                count_q  <= word_count;
                rd_addr  <= (first_addr > LAST_ADDR) ? '0 : first_addr;
                issued   <= '0;
                sent     <= '0;
                checksum <= '0;
            end else begin
                if (issue) begin
                    rd_addr   <= (rd_addr == LAST_ADDR) ? '0 : rd_addr + ONE;
                    addr_hold <= rd_addr;
                    issued    <= issued + ONE;
                end
                if (pop) begin
                    sent     <= sent + ONE;
                    checksum <= checksum + fifo_head;
                end
            end

            // The read issued last cycle has its data on mem_data now.
            case ({inflight, pop})
                2'b10: begin
                    if (fifo_count == 2'd0) fifo_head <= mem_data;
                    else                    fifo_tail <= mem_data;
                    fifo_count <= fifo_count + 2'd1;
                end
                2'b01: begin
                    fifo_head  <= fifo_tail;
                    fifo_count <= fifo_count - 2'd1;
                end
                2'b11: begin
                    if (fifo_count == 2'd1) begin
                        fifo_head <= mem_data;
                    end else begin
                        fifo_head <= fifo_tail;
                        fifo_tail <= mem_data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_stream_reader.sv
// Directed bench for ram_stream_reader: 64-word RAM model holding 0x100+i,
// table of dumps plus hand-written zero-count and mid-dump reset sequences.
module tb_ram_stream_reader;

    logic        clock;
    logic        reset;
    logic        start;
    logic [17:0] first_addr;
    logic [17:0] word_count;
    logic [17:0] mem_addr;
    logic [17:0] mem_data;
    logic [17:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
    logic        busy;
    logic        done;
    logic [17:0] checksum;

    int errors = 0;
    int checks = 0;

    ram_stream_reader #(
        .ADDR_SIZE(18),
        .WORD_SIZE(18),
        .MEM_SIZE (64)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .first_addr(first_addr),
        .word_count(word_count),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done),
        .checksum  (checksum)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // RAM model with registered read data; out-of-range addresses read all-ones.
    logic [17:0] mem [64];
    initial for (int i = 0; i < 64; i++) mem[i] = 18'(256 + i);
    always @(posedge clock)
        mem_data <= (mem_addr < 18'd64) ? mem[mem_addr[5:0]] : '1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    typedef struct {
        int first;
        int count;
        bit bp;        // toggle out_ready with the 1,0,0,1,0,1 pattern
        bit chain;     // start in the done cycle of the previous dump
        int exp_first; // first word expected on the stream
        int exp_sum;   // hand-computed checksum
    } vec_t;

    bit rdy_pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

    // Entered at posedge+1 (or later in the same cycle); returns at the sample
    // point of the done cycle.
    task automatic run_dump(input int first, input int count, input bit bp,
                            input int exp_first, input int exp_sum, input bit busy_start);
        int          cyc = 0;
        int          idx = 0;
        int          last_x = -10;
        bit          stalled = 1'b0;
        bit          seen_valid = 1'b0;
        bit          finished = 1'b0;
        logic [17:0] held = '0;
        int          exp_word;

        start      = 1'b1;
        first_addr = 18'(first);
        word_count = 18'(count);
        out_ready  = bp ? rdy_pat[0] : 1'b1;
        #1;
        @(posedge clock); #1;
        cyc = 1;
        while (cyc < 300 && !finished) begin
            out_ready = bp ? rdy_pat[cyc % 6] : 1'b1;
            if (busy_start && cyc == 5) begin
                start      = 1'b1;
                first_addr = 18'd30;
                word_count = 18'd3;
            end else begin
                start = 1'b0;
            end
            #1;
            if (cyc == 1) check("busy_after_start", 32'(busy), 32'd1);
            check("fifo_count_max", 32'(dut.fifo_count <= 2'd2), 32'd1);
            if (out_valid) begin
                exp_word = 'h100 + ((exp_first - 'h100 + idx) % 64);
                if (!seen_valid) check("first_valid_latency", 32'(cyc), 32'd3);
                seen_valid = 1'b1;
                check("out_data", 32'(out_data), 32'(exp_word));
                check("out_last", 32'(out_last), 32'(idx == count - 1));
                if (stalled) check("stall_stable", 32'(out_data), 32'(held));
                if (out_ready) begin
                    if (!bp) check("throughput", 32'(cyc), 32'(3 + idx));
                    idx++;
                    last_x  = cyc;
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    held    = out_data;
                end
            end else if (stalled) begin
                check("valid_dropped", 32'(out_valid), 32'd1);
                stalled = 1'b0;
            end
            if (done) begin
                check("done_timing", 32'(cyc), 32'(last_x + 1));
                check("word_total", 32'(idx), 32'(count));
                check("busy_in_done", 32'(busy), 32'd0);
                check("checksum", 32'(checksum), 32'(exp_sum));
                finished = 1'b1;
            end else begin
                @(posedge clock); #1;
                cyc++;
            end
        end
        check("done_timeout", 32'(finished), 32'd1);
    endtask

    vec_t vecs [6];
    int   xfers;

    initial begin
        vecs[0] = '{first: 0,   count: 4, bp: 1'b0, chain: 1'b0, exp_first: 'h100, exp_sum: 'h406};
        vecs[1] = '{first: 62,  count: 4, bp: 1'b0, chain: 1'b0, exp_first: 'h13E, exp_sum: 'h47E};
        vecs[2] = '{first: 0,   count: 6, bp: 1'b1, chain: 1'b0, exp_first: 'h100, exp_sum: 'h60F};
        vecs[3] = '{first: 100, count: 3, bp: 1'b0, chain: 1'b0, exp_first: 'h100, exp_sum: 'h303};
        vecs[4] = '{first: 63,  count: 1, bp: 1'b0, chain: 1'b1, exp_first: 'h13F, exp_sum: 'h13F};
        vecs[5] = '{first: 10,  count: 2, bp: 1'b1, chain: 1'b1, exp_first: 'h10A, exp_sum: 'h215};

        reset      = 1'b1;
        start      = 1'b0;
        first_addr = '0;
        word_count = '0;
        out_ready  = 1'b0;
        repeat (3) @(posedge clock);
        #2;
        check("rst_busy",      32'(busy),      32'd0);
        check("rst_done",      32'(done),      32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_last",  32'(out_last),  32'd0);
        check("rst_out_data",  32'(out_data),  32'd0);
        check("rst_mem_addr",  32'(mem_addr),  32'd0);
        check("rst_checksum",  32'(checksum),  32'd0);
        reset = 1'b0;

        for (int i = 0; i < 6; i++) begin
            if (!vecs[i].chain) begin
                repeat (2) begin @(posedge clock); #1; end
            end
            run_dump(vecs[i].first, vecs[i].count, vecs[i].bp,
                     vecs[i].exp_first, vecs[i].exp_sum, 1'b0);
        end

        // Second start while a 10-word dump is busy must be ignored.
        repeat (2) begin @(posedge clock); #1; end
        run_dump(0, 10, 1'b0, 'h100, 'hA2D, 1'b1);

        // Zero-length dump: done the next cycle, no words, never busy.
        repeat (2) begin @(posedge clock); #1; end
        start      = 1'b1;
        first_addr = 18'd7;
        word_count = 18'd0;
        out_ready  = 1'b1;
        #1;
        @(posedge clock); #1;
        start = 1'b0;
        #1;
        check("zero_done",      32'(done),      32'd1);
        check("zero_busy",      32'(busy),      32'd0);
        check("zero_out_valid", 32'(out_valid), 32'd0);
        @(posedge clock); #2;
        check("zero_done_once", 32'(done),      32'd0);
        check("zero_valid_off", 32'(out_valid), 32'd0);

        // Reset after two transfers of an 8-word dump.
        @(posedge clock); #1;
        start      = 1'b1;
        first_addr = 18'd0;
        word_count = 18'd8;
        #1;
        @(posedge clock); #1;
        start = 1'b0;
        xfers = 0;
        for (int c = 1; c < 20 && xfers < 2; c++) begin
            #1;
            if (out_valid && out_ready) xfers++;
            if (xfers < 2) begin @(posedge clock); #1; end
        end
        check("pre_reset_xfers", 32'(xfers), 32'd2);
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        #1;
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_busy",      32'(busy),      32'd0);
        check("mid_rst_checksum",  32'(checksum),  32'd0);
        check("mid_rst_out_last",  32'(out_last),  32'd0);
        check("mid_rst_done",      32'(done),      32'd0);
        @(posedge clock); #1;
        run_dump(5, 2, 1'b0, 'h105, 'h20B, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
